circuito_projeto_uc: RTL and testbench

Control unit that sequences `circuito_projeto_fd` through a periodic measure–classify–report–actuate cycle. Each cycle:
- resets the per-cycle datapath state and waits 1 s;
- triggers the three-sensor measurement, then runs classification;
- transmits the 4-character ASCII frame (3 hex digits of the average plus '#');
- drives the buzzers and automatic valve from the latched classification, then holds before the next cycle.

All handshakes with the datapath are level/pulse signals on a single clock.

---
 rtl/circuito_projeto_uc.sv | 187 ++++++++++++++++++
 tb/tb_circuito_projeto_uc.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circuito_projeto_uc.sv
// Control unit for circuito_projeto_fd: measure, classify, report over serial, actuate, repeat.
// Define MEDIDA_TIMEOUT_EN to build the AGUARDA_MEDIDA watchdog (limit TIMEOUT_CICLOS).
module circuito_projeto_uc #(
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_1s,
    input  logic       fim_2s,
    input  logic       fim_estado4,
    input  logic       fim_medida,
    input  logic       fim_classificacao,
    input  logic       descartar_medida,
    input  logic [2:0] medida_classificacao,
    input  logic       fim_carater,
    input  logic       fim_mensagem,
    output logic       zera,
    output logic       zera_vlv,
    output logic       conta_1s,
    output logic       conta_2s,
    output logic       conta_estado4,
    output logic       mensurar,
    output logic       analisa_medida,
    output logic       envia,
    output logic       muda,
    output logic       liga_buzzer_baixa,
    output logic       liga_buzzer_alta,
    output logic       desliga_buzzers,
    output logic       abre_valvula_auto,
    output logic       fecha_valvula_auto,
    output logic       erro_medida,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        ZERA_CICLO     = 4'd2,
        ESPERA         = 4'd3,
        MEDE           = 4'd4,
        AGUARDA_MEDIDA = 4'd5,
        ANALISA        = 4'd6,
        TRANSMITE      = 4'd7,
        AGUARDA_TX     = 4'd8,
        PROXIMO        = 4'd9,
        ATUA           = 4'd10,
        ALERTA         = 4'd11,
        AGUARDA_2S     = 4'd12
    } estado_t;

    localparam logic [2:0] CLASSE_BAIXO   = 3'b001;
    localparam logic [2:0] CLASSE_ALTO    = 3'b011;
    localparam logic [2:0] CLASSE_CRITICO = 3'b100;

    estado_t    estado;
    estado_t    proximo;
    logic [2:0] classe_reg;
    logic       timeout;

`ifdef MEDIDA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

    logic [CW-1:0] cont_timeout;

    // Counter runs only while waiting for the sensors; any other state holds it at zero.
    always_ff @(posedge clock) begin
        if (reset || estado != AGUARDA_MEDIDA) begin
            cont_timeout <= '0;
        end else begin
            cont_timeout <= cont_timeout + CW'(1);
        end
    end

    assign timeout = (estado == AGUARDA_MEDIDA) &&
                     (cont_timeout == CW'(TIMEOUT_CICLOS - 1)) && !fim_medida;
`else
    // Without the watchdog this is constant 0 for any sensible limit.
    assign timeout = (TIMEOUT_CICLOS < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            classe_reg <= 3'b000;
        end else begin
            estado <= proximo;
            if (estado == ANALISA && fim_classificacao) begin
                classe_reg <= medida_classificacao;
            end
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = ligar ? PREPARA : INICIAL;
            PREPARA:        proximo = ESPERA;
            ZERA_CICLO:     proximo = ESPERA;
            ESPERA: begin
                if (!ligar)      proximo = INICIAL;
                else if (fim_1s) proximo = MEDE;
                else             proximo = ESPERA;
            end
            MEDE:           proximo = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                if (fim_medida)   proximo = ANALISA;
                else if (timeout) proximo = ZERA_CICLO;
                else              proximo = AGUARDA_MEDIDA;
            end
            ANALISA: begin
                if (!fim_classificacao)   proximo = ANALISA;
                else if (descartar_medida) proximo = ZERA_CICLO;
                else                       proximo = TRANSMITE;
            end
            TRANSMITE:      proximo = AGUARDA_TX;
            AGUARDA_TX:     proximo = fim_carater ? PROXIMO : AGUARDA_TX;
            PROXIMO:        proximo = fim_mensagem ? ATUA : TRANSMITE;
            ATUA:           proximo = (classe_reg == CLASSE_CRITICO) ? ALERTA : AGUARDA_2S;
            ALERTA:         proximo = fim_estado4 ? AGUARDA_2S : ALERTA;
            AGUARDA_2S: begin
                if (!ligar)      proximo = INICIAL;
                else if (fim_2s) proximo = ZERA_CICLO;
                else             proximo = AGUARDA_2S;
            end
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        zera               = 1'b0;
        zera_vlv           = 1'b0;
        conta_1s           = 1'b0;
        conta_2s           = 1'b0;
        conta_estado4      = 1'b0;
        mensurar           = 1'b0;
        analisa_medida     = 1'b0;
        envia              = 1'b0;
        muda               = 1'b0;
        liga_buzzer_baixa  = 1'b0;
        liga_buzzer_alta   = 1'b0;
        desliga_buzzers    = 1'b0;
        abre_valvula_auto  = 1'b0;
        fecha_valvula_auto = 1'b0;
        pronto             = 1'b0;
        case (estado)
            INICIAL:    pronto = 1'b1;
            PREPARA: begin
                zera     = 1'b1;
                zera_vlv = 1'b1;
            end
            ZERA_CICLO: zera = 1'b1;
            ESPERA:     conta_1s = 1'b1;
            MEDE:       mensurar = 1'b1;
            ANALISA:    analisa_medida = 1'b1;
            TRANSMITE:  envia = 1'b1;
            PROXIMO:    muda = 1'b1;
            ATUA: begin
                // Unknown class codes fall through to the normal (buzzers off) action.
                case (classe_reg)
                    CLASSE_BAIXO: begin
                        liga_buzzer_baixa = 1'b1;
                        abre_valvula_auto = 1'b1;
                    end
                    CLASSE_ALTO: begin
                        liga_buzzer_alta   = 1'b1;
                        fecha_valvula_auto = 1'b1;
                    end
                    CLASSE_CRITICO: begin
                        liga_buzzer_baixa  = 1'b1;
                        liga_buzzer_alta   = 1'b1;
                        fecha_valvula_auto = 1'b1;
                    end
                    default: desliga_buzzers = 1'b1;
                endcase
            end
            ALERTA:     conta_estado4 = 1'b1;
            AGUARDA_2S: conta_2s = 1'b1;
            default: ;
        endcase
    end

    assign erro_medida = timeout;
    assign db_estado   = estado;

endmodule

// File: tb/tb_circuito_projeto_uc.sv
// Self-checking bench for circuito_projeto_uc: expected state/output words are queued per
// driven cycle and compared against words captured from the DUT on the falling edge.
module tb_circuito_projeto_uc;

    logic       clock;
    logic       reset;
    logic       ligar;
    logic       fim_1s;
    logic       fim_2s;
    logic       fim_estado4;
    logic       fim_medida;
    logic       fim_classificacao;
    logic       descartar_medida;
    logic [2:0] medida_classificacao;
    logic       fim_carater;
    logic       fim_mensagem;
    logic       zera;
    logic       zera_vlv;
    logic       conta_1s;
    logic       conta_2s;
    logic       conta_estado4;
    logic       mensurar;
    logic       analisa_medida;
    logic       envia;
    logic       muda;
    logic       liga_buzzer_baixa;
    logic       liga_buzzer_alta;
    logic       desliga_buzzers;
    logic       abre_valvula_auto;
    logic       fecha_valvula_auto;
    logic       erro_medida;
    logic       pronto;
    logic [3:0] db_estado;

    int          n_compared = 0;
    int          n_failed   = 0;
    logic        mon_en     = 1'b0;
    logic [2:0]  exp_cls    = 3'b000;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    circuito_projeto_uc dut (
        .clock                (clock),
        .reset                (reset),
        .ligar                (ligar),
        .fim_1s               (fim_1s),
        .fim_2s               (fim_2s),
        .fim_estado4          (fim_estado4),
        .fim_medida           (fim_medida),
        .fim_classificacao    (fim_classificacao),
        .descartar_medida     (descartar_medida),
        .medida_classificacao (medida_classificacao),
        .fim_carater          (fim_carater),
        .fim_mensagem         (fim_mensagem),
        .zera                 (zera),
        .zera_vlv             (zera_vlv),
        .conta_1s             (conta_1s),
        .conta_2s             (conta_2s),
        .conta_estado4        (conta_estado4),
        .mensurar             (mensurar),
        .analisa_medida       (analisa_medida),
        .envia                (envia),
        .muda                 (muda),
        .liga_buzzer_baixa    (liga_buzzer_baixa),
        .liga_buzzer_alta     (liga_buzzer_alta),
        .desliga_buzzers      (desliga_buzzers),
        .abre_valvula_auto    (abre_valvula_auto),
        .fecha_valvula_auto   (fecha_valvula_auto),
        .erro_medida          (erro_medida),
        .pronto               (pronto),
        .db_estado            (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Word layout: {state[3:0], zera, zera_vlv, conta_1s, conta_2s, conta_estado4, mensurar,
    // analisa, envia, muda, buz_baixa, buz_alta, desliga, abre, fecha, erro, pronto}
    always @(negedge clock) begin
        if (mon_en) begin
            obs_q.push_back({db_estado, zera, zera_vlv, conta_1s, conta_2s, conta_estado4,
                             mensurar, analisa_medida, envia, muda, liga_buzzer_baixa,
                             liga_buzzer_alta, desliga_buzzers, abre_valvula_auto,
                             fecha_valvula_auto, erro_medida, pronto});
        end
    end

    function automatic logic [19:0] exp_out(input logic [3:0] st, input logic [2:0] cls);
        logic [15:0] f;
        f = '0;
        case (st)
            4'd0:  f[0] = 1'b1;
            4'd1:  begin f[15] = 1'b1; f[14] = 1'b1; end
            4'd2:  f[15] = 1'b1;
            4'd3:  f[13] = 1'b1;
            4'd4:  f[10] = 1'b1;
            4'd6:  f[9] = 1'b1;
            4'd7:  f[8] = 1'b1;
            4'd9:  f[7] = 1'b1;
            4'd10: begin
                case (cls)
                    3'b001:  begin f[6] = 1'b1; f[3] = 1'b1; end
                    3'b011:  begin f[5] = 1'b1; f[2] = 1'b1; end
                    3'b100:  begin f[6] = 1'b1; f[5] = 1'b1; f[2] = 1'b1; end
                    default: f[4] = 1'b1;
                endcase
            end
            4'd11: f[11] = 1'b1;
            4'd12: f[12] = 1'b1;
            default: ;
        endcase
        return {st, f};
    endfunction

    // One clock: queue what the word must look like after the next rising edge.
    task automatic step(input logic [3:0] st);
        exp_q.push_back(exp_out(st, exp_cls));
        @(negedge clock);
        #1;
    endtask

    // From ESPERA through a full 4-character frame, ending in ATUA.
    task automatic run_to_atua(input logic [2:0] cls, input logic drop_ligar);
        fim_1s = 1'b1; step(4'd4);
        fim_1s = 1'b0; step(4'd5);
        step(4'd5);
        fim_medida = 1'b1; step(4'd6);
        fim_medida = 1'b0; step(4'd6);
        medida_classificacao = cls; fim_classificacao = 1'b1; exp_cls = cls; step(4'd7);
        fim_classificacao = 1'b0;
        if (drop_ligar) ligar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(4'd8);
            fim_carater = 1'b1; step(4'd9);
            fim_carater = 1'b0; fim_mensagem = (i == 3); step((i == 3) ? 4'd10 : 4'd7);
            fim_mensagem = 1'b0;
        end
    endtask

    task automatic applyStimulus_finish_cycle();
        fim_2s = 1'b1; step(4'd2);
        fim_2s = 1'b0; step(4'd3);
    endtask

    task automatic test_reset();
        reset = 1'b1; ligar = 1'b0; fim_1s = 1'b0; fim_2s = 1'b0; fim_estado4 = 1'b0;
        fim_medida = 1'b0; fim_classificacao = 1'b0; descartar_medida = 1'b0;
        medida_classificacao = 3'b000; fim_carater = 1'b0; fim_mensagem = 1'b0;
        mon_en = 1'b1;
        step(4'd0);
        step(4'd0);
        reset = 1'b0; step(4'd0);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL reset word: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_start();
        int n_vlv = 0;
        ligar = 1'b1; step(4'd1);
        step(4'd3);
        step(4'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_vlv += int'(o[14]);
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL start word: got %h expected %h", o, e);
            end
        end
        n_compared++;
        if (n_vlv !== 1) begin
            n_failed++;
            $display("[TB] FAIL start zera_vlv pulses: got %0d expected 1", n_vlv);
        end
    endtask

    task automatic test_normal_frame();
        int n_env = 0, n_muda = 0, n_desl = 0;
        run_to_atua(3'b010, 1'b0);
        step(4'd12);
        step(4'd12);
        applyStimulus_finish_cycle();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_env += int'(o[8]); n_muda += int'(o[7]); n_desl += int'(o[4]);
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL normal_frame word: got %h expected %h", o, e);
            end
        end
        n_compared++;
        if (n_env !== 4 || n_muda !== 4 || n_desl !== 1) begin
            n_failed++;
            $display("[TB] FAIL normal_frame pulses: got envia=%0d muda=%0d desliga=%0d expected 4/4/1",
                     n_env, n_muda, n_desl);
        end
    endtask

    task automatic test_back_to_back();
        int n_vlv = 0, n_env = 0;
        logic [2:0] classes [3] = '{3'b001, 3'b011, 3'b010};
        for (int k = 0; k < 3; k++) begin
            run_to_atua(classes[k], 1'b0);
            step(4'd12);
            applyStimulus_finish_cycle();
        end
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_vlv += int'(o[14]); n_env += int'(o[8]);
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL back_to_back word: got %h expected %h", o, e);
            end
        end
        n_compared++;
        if (n_vlv !== 0 || n_env !== 12) begin
            n_failed++;
            $display("[TB] FAIL back_to_back pulses: got zera_vlv=%0d envia=%0d expected 0/12", n_vlv, n_env);
        end
    endtask

    task automatic test_classes();
        logic [2:0] classes [4] = '{3'b000, 3'b101, 3'b111, 3'b100};
        for (int k = 0; k < 3; k++) begin
            run_to_atua(classes[k], 1'b0);
            step(4'd12);
            applyStimulus_finish_cycle();
        end
        // Critical class: alert holds until fim_estado4; stale flags must not skip states.
        run_to_atua(classes[3], 1'b0);
        step(4'd11);
        step(4'd11);
        step(4'd11);
        fim_estado4 = 1'b1; step(4'd12);
        step(4'd12);
        fim_estado4 = 1'b0; fim_2s = 1'b1; step(4'd2);
        step(4'd3);
        fim_2s = 1'b0; step(4'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL classes word: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_discard();
        int n_env = 0;
        fim_1s = 1'b1; step(4'd4);
        fim_1s = 1'b0; step(4'd5);
        fim_medida = 1'b1; step(4'd6);
        fim_medida = 1'b0;
        medida_classificacao = 3'b011; fim_classificacao = 1'b1; descartar_medida = 1'b1;
        exp_cls = 3'b011; step(4'd2);
        fim_classificacao = 1'b0; descartar_medida = 1'b0; step(4'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_env += int'(o[8]);
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL discard word: got %h expected %h", o, e);
            end
        end
        n_compared++;
        if (n_env !== 0) begin
            n_failed++;
            $display("[TB] FAIL discard envia pulses: got %0d expected 0", n_env);
        end
    endtask

    task automatic test_ligar_off_espera();
        ligar = 1'b0; fim_1s = 1'b1; step(4'd0);
        fim_1s = 1'b0; step(4'd0);
        ligar = 1'b1; step(4'd1);
        step(4'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL ligar_off_espera word: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_ligar_off_transmite();
        int n_env = 0;
        run_to_atua(3'b010, 1'b1);
        fim_2s = 1'b1; step(4'd12);
        step(4'd0);
        fim_2s = 1'b0; ligar = 1'b1; step(4'd1);
        step(4'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_env += int'(o[8]);
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL ligar_off_tx word: got %h expected %h", o, e);
            end
        end
        n_compared++;
        if (n_env !== 4) begin
            n_failed++;
            $display("[TB] FAIL ligar_off_tx envia pulses: got %0d expected 4", n_env);
        end
    endtask

    task automatic test_reset_mid();
        fim_1s = 1'b1; step(4'd4);
        fim_1s = 1'b0; step(4'd5);
        step(4'd5);
        reset = 1'b1; exp_cls = 3'b000; step(4'd0);
        reset = 1'b0; ligar = 1'b0; step(4'd0);
        ligar = 1'b1; step(4'd1);
        step(4'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            n_compared++;
            if (o !== e) begin
                n_failed++;
                $display("[TB] FAIL reset_mid word: got %h expected %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_normal_frame();
        test_back_to_back();
        test_classes();
        test_discard();
        test_ligar_off_espera();
        test_ligar_off_transmite();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
